// File: rtl/exec_pkg.sv
// Shared constants and types for the 20-bit execute stage.
package exec_pkg;

  localparam int DATA_W   = 20;
  localparam int MUL_ITER = 20;

  // Instruction field positions
  localparam int OPC_LSB = 16;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 12;
  localparam int RD_W    = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd4;
  localparam logic [OPC_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'd6;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'd7;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'd8;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_DONE
  } state_t;

  // Opcodes 1..9 write rd; everything else is a bubble
  function automatic logic writes_rd(input logic [OPC_W-1:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_SHR);
  endfunction

endpackage

// File: rtl/exec_if.sv
// ID/EX -> EX -> EX/MEM bus for the execute stage.
interface exec_if
  import exec_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] instruction_in;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] store_data;
  logic [RD_W-1:0]  dest_reg;
  logic             reg_write;
  logic             valid_out;
  logic [WIDTH-1:0] instruction_out;
  logic             stall;

  // Upstream / downstream side
  modport master (
    output instruction_in, operand1, operand2,
    input  alu_result, store_data, dest_reg, reg_write, valid_out,
           instruction_out, stall
  );

  // Execute stage side
  modport slave (
    input  instruction_in, operand1, operand2,
    output alu_result, store_data, dest_reg, reg_write, valid_out,
           instruction_out, stall
  );

endinterface

// File: rtl/mul_iter20.sv
// Shift-add multiplier: one multiplier bit per step, low WIDTH bits kept.
module mul_iter20
  import exec_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int ITER  = MUL_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] product,
  output logic             last,
  output logic             done
);

  localparam int CW = $clog2(ITER);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  assign last    = (cnt_q == CW'(ITER - 1));
  assign product = acc_q;
  assign done    = done_q;

  // Load on start, otherwise add the shifted multiplicand for each set multiplier bit
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    if (start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
    end else if (step && !done_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (last) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Multiplier state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply with upstream stall.
module execute_stage #(
  parameter int WIDTH    = exec_pkg::DATA_W,
  parameter int MUL_ITER = exec_pkg::MUL_ITER
) (
  input  logic  clock,
  input  logic  reset,
  exec_if.slave bus
);
  import exec_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] store_data_q, store_data_d;
  logic [RD_W-1:0]  dest_reg_q, dest_reg_d;
  logic             reg_write_q, reg_write_d;
  logic [WIDTH-1:0] instr_out_q, instr_out_d;
  logic [WIDTH-1:0] mul_instr_q, mul_instr_d;
  logic [WIDTH-1:0] mul_store_q, mul_store_d;

  logic [OPC_W-1:0] opcode;
  logic [RD_W-1:0]  rd;
  logic [IMM_W-1:0] imm8;
  logic [WIDTH-1:0] imm_ext;
  logic [SH_W-1:0]  shamt;
  logic             shift_oob;
  logic [WIDTH-1:0] alu_val;
  logic             stall_c;
  logic             mul_start, mul_step, mul_last, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign opcode    = bus.instruction_in[OPC_LSB +: OPC_W];
  assign rd        = bus.instruction_in[RD_LSB +: RD_W];
  assign imm8      = bus.instruction_in[IMM_LSB +: IMM_W];
  assign imm_ext   = {{(WIDTH - IMM_W){imm8[IMM_W-1]}}, imm8};
  assign shamt     = bus.operand2[SH_W-1:0];
  assign shift_oob = (int'(shamt) >= WIDTH);

  mul_iter20 #(
    .WIDTH (WIDTH),
    .ITER  (MUL_ITER)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .op_a    (bus.operand1),
    .op_b    (bus.operand2),
    .product (mul_product),
    .last    (mul_last),
    .done    (mul_done)
  );

  // Single-cycle ALU result for the instruction currently on the inputs
  always_comb begin
    alu_val = '0;
    case (opcode)
      OP_ADD:  alu_val = bus.operand1 + bus.operand2;
      OP_SUB:  alu_val = bus.operand1 - bus.operand2;
      OP_AND:  alu_val = bus.operand1 & bus.operand2;
      OP_OR:   alu_val = bus.operand1 | bus.operand2;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(bus.operand1) < $signed(bus.operand2))};
      OP_ADDI: alu_val = bus.operand1 + imm_ext;
      OP_SHL:  alu_val = shift_oob ? '0 : (bus.operand1 << shamt);
      OP_SHR:  alu_val = shift_oob ? '0 : (bus.operand1 >> shamt);
      default: alu_val = '0;
    endcase
  end

  // FSM next state and EX/MEM next values; bubble unless something is written
  always_comb begin
    state_d      = state_q;
    alu_result_d = '0;
    store_data_d = '0;
    dest_reg_d   = '0;
    reg_write_d  = 1'b0;
    instr_out_d  = '0;
    mul_instr_d  = mul_instr_q;
    mul_store_d  = mul_store_q;
    stall_c      = 1'b0;
    mul_start    = 1'b0;
    mul_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (opcode == OP_MUL) begin
          stall_c     = 1'b1;
          mul_start   = 1'b1;
          mul_instr_d = bus.instruction_in;
          mul_store_d = bus.operand2;
          state_d     = MUL_RUN;
        end else begin
          alu_result_d = alu_val;
          store_data_d = bus.operand2;
          dest_reg_d   = rd;
          reg_write_d  = writes_rd(opcode);
          instr_out_d  = bus.instruction_in;
        end
      end
      MUL_RUN: begin
        stall_c  = 1'b1;
        mul_step = 1'b1;
        if (mul_last) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        alu_result_d = mul_product;
        store_data_d = mul_store_q;
        dest_reg_d   = mul_instr_q[RD_LSB +: RD_W];
        reg_write_d  = mul_done;
        instr_out_d  = mul_instr_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured MUL context and EX/MEM output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      alu_result_q <= '0;
      store_data_q <= '0;
      dest_reg_q   <= '0;
      reg_write_q  <= 1'b0;
      instr_out_q  <= '0;
      mul_instr_q  <= '0;
      mul_store_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      dest_reg_q   <= dest_reg_d;
      reg_write_q  <= reg_write_d;
      instr_out_q  <= instr_out_d;
      mul_instr_q  <= mul_instr_d;
      mul_store_q  <= mul_store_d;
    end
  end

  assign bus.alu_result      = alu_result_q;
  assign bus.store_data      = store_data_q;
  assign bus.dest_reg        = dest_reg_q;
  assign bus.reg_write       = reg_write_q;
  assign bus.valid_out       = reg_write_q;
  assign bus.instruction_out = instr_out_q;
  assign bus.stall           = stall_c & reset;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table plus multiply sequences.
module tb_execute_stage;
  import exec_pkg::*;

  typedef struct packed {
    logic [3:0]  opc;
    logic [3:0]  rd;
    logic [19:0] a;
    logic [19:0] b;
    logic [7:0]  imm;
    logic [19:0] exp;
    logic        exp_valid;
  } vec_t;

  typedef struct packed {
    logic [19:0] result;
    logic        valid;
    logic [3:0]  rd;
    logic [19:0] instr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  vec_t vecs[15];

  exec_if #(.WIDTH(20)) bus();

  execute_stage #(.WIDTH(20), .MUL_ITER(20)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10-unit clock period
  always #5 clock = ~clock;

  // Free-running cycle counter for latency measurements
  always @(posedge clock) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [3:0] opc, input logic [3:0] rd,
                              input logic [19:0] a, input logic [19:0] b,
                              input logic [7:0] imm, input logic [19:0] exp,
                              input logic ev);
    vec_t v;
    v.opc = opc; v.rd = rd; v.a = a; v.b = b; v.imm = imm;
    v.exp = exp; v.exp_valid = ev;
    return v;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one instruction; optionally record what the DUT must produce for it
  task automatic applyStimulus(input vec_t v, input bit push);
    exp_t e;
    logic [19:0] instr;
    instr = {v.opc, v.rd, 4'h0, v.imm};
    bus.instruction_in = instr;
    bus.operand1       = v.a;
    bus.operand2       = v.b;
    if (push) begin
      e.result = v.exp;
      e.valid  = v.exp_valid;
      e.rd     = v.rd;
      e.instr  = instr;
      sb.push_back(e);
    end
  endtask

  // Pop the oldest expectation and compare against the EX/MEM outputs
  task automatic checkFront(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, got alu_result=0x%0h, expected an entry", name, bus.alu_result);
    end else begin
      e = sb.pop_front();
      checkOutput({name, " alu_result"}, 32'(bus.alu_result), 32'(e.result));
      checkOutput({name, " valid_out"}, 32'(bus.valid_out), 32'(e.valid));
      checkOutput({name, " reg_write"}, 32'(bus.reg_write), 32'(e.valid));
      if (e.valid) begin
        checkOutput({name, " dest_reg"}, 32'(bus.dest_reg), 32'(e.rd));
        checkOutput({name, " instruction_out"}, 32'(bus.instruction_out), 32'(e.instr));
      end
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " alu_result"}, 32'(bus.alu_result), 0);
    checkOutput({name, " store_data"}, 32'(bus.store_data), 0);
    checkOutput({name, " dest_reg"}, 32'(bus.dest_reg), 0);
    checkOutput({name, " reg_write"}, 32'(bus.reg_write), 0);
    checkOutput({name, " valid_out"}, 32'(bus.valid_out), 0);
    checkOutput({name, " instruction_out"}, 32'(bus.instruction_out), 0);
    checkOutput({name, " stall"}, 32'(bus.stall), 0);
  endtask

  // A MUL is on the inputs this cycle: count stall, check bubbles, then advance upstream
  task automatic mulWait(input string name, input vec_t nxt, output int done_cyc);
    int stall_cnt;
    int bubble_errs;
    stall_cnt   = 0;
    bubble_errs = 0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (bus.stall !== 1'b1) break;
      stall_cnt++;
      tick();
      if (bus.valid_out !== 1'b0 || bus.reg_write !== 1'b0 || bus.alu_result !== 20'h0)
        bubble_errs++;
      #1;
    end
    checkOutput({name, " stall cycles"}, 32'(stall_cnt), 21);
    checkOutput({name, " bubbles"}, 32'(bubble_errs), 0);
    applyStimulus(nxt, 1'b1);
    tick();
    done_cyc = cyc;
    checkFront(name);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vec_t nop;
    int   start_cyc;
    int   c1;
    int   c2;

    vecs[0]  = mk(OP_ADD,  4'd1,  20'd5,      20'd7,      8'h00, 20'd12,     1'b1);
    vecs[1]  = mk(OP_SUB,  4'd2,  20'd3,      20'd5,      8'h00, 20'hFFFFE,  1'b1);
    vecs[2]  = mk(OP_AND,  4'd3,  20'hF0F0F,  20'h0FF00,  8'h00, 20'h00F00,  1'b1);
    vecs[3]  = mk(OP_OR,   4'd4,  20'hF0000,  20'h0000F,  8'h00, 20'hF000F,  1'b1);
    vecs[4]  = mk(OP_SLT,  4'd5,  20'hFFFFF,  20'd1,      8'h00, 20'd1,      1'b1);
    vecs[5]  = mk(OP_SLT,  4'd6,  20'd1,      20'hFFFFF,  8'h00, 20'd0,      1'b1);
    vecs[6]  = mk(OP_ADDI, 4'd7,  20'd10,     20'd0,      8'hFE, 20'd8,      1'b1);
    vecs[7]  = mk(OP_SHL,  4'd8,  20'd1,      20'd19,     8'h00, 20'h80000,  1'b1);
    vecs[8]  = mk(OP_SHR,  4'd9,  20'h80000,  20'd25,     8'h00, 20'd0,      1'b1);
    vecs[9]  = mk(OP_SHR,  4'd10, 20'h80000,  20'd19,     8'h00, 20'd1,      1'b1);
    vecs[10] = mk(OP_SHL,  4'd11, 20'd1,      20'd20,     8'h00, 20'd0,      1'b1);
    vecs[11] = mk(4'd12,   4'd12, 20'd5,      20'd7,      8'h00, 20'd0,      1'b0);
    vecs[12] = mk(OP_NOP,  4'd13, 20'd9,      20'd9,      8'h00, 20'd0,      1'b0);
    vecs[13] = mk(OP_ADD,  4'd14, 20'hFFFFF,  20'd1,      8'h00, 20'd0,      1'b1);
    vecs[14] = mk(OP_SHL,  4'd15, 20'd3,      20'h00021,  8'h00, 20'd6,      1'b1);
    nop      = mk(OP_NOP,  4'd0,  20'd0,      20'd0,      8'h00, 20'd0,      1'b0);

    // Power-on reset, then release just after an edge
    applyStimulus(nop, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkResetOutputs("por");
    reset = 1'b1;

    // Single-cycle ALU sweep
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], 1'b1);
      #1;
      checkOutput($sformatf("vec%0d stall", i), 32'(bus.stall), 0);
      tick();
      checkFront($sformatf("vec%0d", i));
    end

    // Reset asserted mid-stream clears outputs immediately
    applyStimulus(mk(OP_ADD, 4'd1, 20'd1, 20'd2, 8'h00, 20'd3, 1'b1), 1'b1);
    tick();
    checkFront("pre-reset add");
    reset = 1'b0;
    #1;
    checkResetOutputs("mid reset");
    tick();
    checkResetOutputs("reset held");
    applyStimulus(mk(OP_ADD, 4'd2, 20'd5, 20'd7, 8'h00, 20'd12, 1'b1), 1'b1);
    reset = 1'b1;
    tick();
    checkFront("add after reset");

    // MUL 123 x 45, followed by a NOP to show the held MUL is not re-run
    v = mk(OP_MUL, 4'd3, 20'd123, 20'd45, 8'h00, 20'd5535, 1'b1);
    applyStimulus(v, 1'b1);
    start_cyc = cyc;
    mulWait("mul123x45", nop, c1);
    checkOutput("mul123x45 latency", 32'(c1 - start_cyc), 22);
    #1;
    checkOutput("mul123x45 stall after", 32'(bus.stall), 0);
    tick();
    checkFront("nop after mul");

    // Overflowing MUL, ADD follows straight after the stall drops
    v = mk(OP_MUL, 4'd4, 20'hFFFFF, 20'hFFFFF, 8'h00, 20'h00001, 1'b1);
    applyStimulus(v, 1'b1);
    mulWait("mul overflow", mk(OP_ADD, 4'd5, 20'd100, 20'd23, 8'h00, 20'd123, 1'b1), c1);
    tick();
    checkFront("add after mul");

    // Back-to-back MULs
    v = mk(OP_MUL, 4'd6, 20'd3, 20'd4, 8'h00, 20'd12, 1'b1);
    applyStimulus(v, 1'b1);
    mulWait("mul3x4", mk(OP_MUL, 4'd7, 20'd5, 20'd6, 8'h00, 20'd30, 1'b1), c1);
    mulWait("mul5x6", nop, c2);
    checkOutput("back-to-back spacing", 32'(c2 - c1), 22);
    tick();
    checkFront("nop after back-to-back");

    // Reset in cycle 10 of a MUL abandons it
    applyStimulus(mk(OP_MUL, 4'd8, 20'd7, 20'd9, 8'h00, 20'd63, 1'b1), 1'b0);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    checkResetOutputs("mul abort");
    checkOutput("mul abort state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("mul abort counter", 32'(dut.u_mul.cnt_q), 0);
    applyStimulus(mk(OP_ADD, 4'd9, 20'd9, 20'd1, 8'h00, 20'd10, 1'b1), 1'b1);
    tick();
    reset = 1'b1;
    tick();
    checkFront("add after abort");
    checkOutput("scoreboard drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
